// File: rtl/meas_pred_pipe.sv
// Measurement-domain intra predictor: picks left/top/DC by min SAD, emits quantised residual and mode code.
// Latency 1 clk through a single output register; one block per clock when downstream is ready.
// Backpressure: in_ready = ~out_valid | out_ready; outputs hold while stalled. Define GRAD_EDGE_EN for gradient-corrected edges.
module meas_pred_pipe #(
    parameter int BLK_N          = 4,
    parameter int MEA_N          = 12,
    parameter int PIX_WID        = 8,
    parameter int QSTEP_WID      = 3,
    parameter int PIC_WID_IN_BLK = 64,
    parameter int PIC_HT_IN_BLK  = 64,
    parameter int G_V_IDX        = 4,
    parameter int G_H_IDX        = 1,
    localparam int PIX_N   = BLK_N * BLK_N,
    localparam int LOG2PIX = $clog2(PIX_N),
    localparam int MEA_WID = LOG2PIX + PIX_WID,
    localparam int BX_W    = $clog2(PIC_WID_IN_BLK),
    localparam int BY_W    = $clog2(PIC_HT_IN_BLK)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             sof,
    input  logic [MEA_N-1:0][MEA_WID:0]      y,
    input  logic [QSTEP_WID-1:0]             qstep,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MEA_N-1:0][MEA_WID:0]      y_resQ,
    output logic [1:0]                       code,
    output logic [BX_W-1:0]                  blk_x,
    output logic [BY_W-1:0]                  blk_y,
    output logic                             frame_done
);
    localparam int SAD_W = MEA_WID + $clog2(MEA_N) + 2;
    localparam int RES_W = MEA_WID + 2;
    localparam int REC_W = MEA_WID + 3;
    localparam logic signed [RES_W-1:0] RQ_MAX   = RES_W'((1 << MEA_WID) - 1);
    localparam logic signed [RES_W-1:0] RQ_MIN   = RES_W'(-(1 << MEA_WID));
    localparam logic signed [REC_W:0]   EDGE_MAX = (REC_W+1)'((1 << PIX_WID) - 1);
    localparam logic [1:0] CODE_L = 2'b00, CODE_T = 2'b01, CODE_DC = 2'b11;

    if (G_V_IDX >= MEA_N || G_H_IDX >= MEA_N) begin : g_bad_grad_idx
        $error("gradient measurement index out of range");
    end

    function automatic logic signed [RES_W-1:0] sext(input logic [MEA_WID:0] v);
        return RES_W'($signed(v));
    endfunction

    function automatic logic [RES_W-1:0] abs_diff(input logic signed [RES_W-1:0] a,
                                                  input logic signed [RES_W-1:0] b);
        logic signed [RES_W-1:0] d;
        d = a - b;
        return d[RES_W-1] ? RES_W'(-d) : RES_W'(d);
    endfunction

    // Arithmetic shift then saturate into the output measurement width
    function automatic logic [MEA_WID:0] quant(input logic signed [RES_W-1:0] r,
                                               input logic [QSTEP_WID-1:0] q);
        logic signed [RES_W-1:0] s;
        s = r >>> q;
        if (s > RQ_MAX)      return RQ_MAX[MEA_WID:0];
        else if (s < RQ_MIN) return RQ_MIN[MEA_WID:0];
        else                 return s[MEA_WID:0];
    endfunction

    function automatic logic signed [REC_W-1:0] recon(input logic [MEA_WID:0] rq,
                                                      input logic [QSTEP_WID-1:0] q,
                                                      input logic signed [RES_W-1:0] c);
        logic signed [REC_W-1:0] e;
        e = REC_W'($signed(rq));
        return (e <<< q) + REC_W'(c);
    endfunction

    // DC-row value back to pixel domain, clipped to the pixel range
    function automatic logic [PIX_WID-1:0] clip_edge(input logic signed [REC_W:0] v);
        logic signed [REC_W:0] s;
        s = v >>> LOG2PIX;
        if (s < 0)             return '0;
        else if (s > EDGE_MAX) return EDGE_MAX[PIX_WID-1:0];
        else                   return s[PIX_WID-1:0];
    endfunction

    logic [BX_W-1:0]          cnt_x, cx;
    logic [BY_W-1:0]          cnt_y, cy;
    logic [PIX_WID-1:0]       left_edge, left_nxt, lb_nxt;
    logic [PIX_WID-1:0]       lb [PIC_WID_IN_BLK];
    logic signed [RES_W-1:0]  cand_l, cand_t, cand_dc, cand_sel;
    logic [SAD_W-1:0]         sad_ac, sad_l, sad_t, sad_dc;
    logic [1:0]               code_nxt;
    logic [MEA_N-1:0][MEA_WID:0] rq_nxt;
    logic signed [REC_W-1:0]  rec0;
    logic                     in_fire, last_x, last_y;

    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign cx       = sof ? '0 : cnt_x;
    assign cy       = sof ? '0 : cnt_y;
    assign last_x   = (cx == BX_W'(PIC_WID_IN_BLK - 1));
    assign last_y   = (cy == BY_W'(PIC_HT_IN_BLK - 1));

    assign cand_dc = RES_W'(1 << (PIX_WID - 1 + LOG2PIX));
    assign cand_l  = RES_W'({left_edge, {LOG2PIX{1'b0}}});
    assign cand_t  = RES_W'({lb[cx], {LOG2PIX{1'b0}}});

    // SADs: elements 1..N-1 share a zero candidate, so only element 0 differs
    always_comb begin
        sad_ac = '0;
        for (int i = 1; i < MEA_N; i++)
            sad_ac = sad_ac + SAD_W'(abs_diff(sext(y[i]), '0));
        sad_l  = sad_ac + SAD_W'(abs_diff(sext(y[0]), cand_l));
        sad_t  = sad_ac + SAD_W'(abs_diff(sext(y[0]), cand_t));
        sad_dc = sad_ac + SAD_W'(abs_diff(sext(y[0]), cand_dc));
    end

    // Mode decision; neighbours outside the frame are excluded, ties favour the later candidate
    always_comb begin
        code_nxt = CODE_DC;
        if (cx == '0 && cy == '0)
            code_nxt = CODE_DC;
        else if (cy == '0)
            code_nxt = (sad_l < sad_dc) ? CODE_L : CODE_DC;
        else if (cx == '0)
            code_nxt = (sad_t < sad_dc) ? CODE_T : CODE_DC;
        else if (sad_l < sad_t && sad_l < sad_dc)
            code_nxt = CODE_L;
        else if (sad_t < sad_dc)
            code_nxt = CODE_T;
        case (code_nxt)
            CODE_L:  cand_sel = cand_l;
            CODE_T:  cand_sel = cand_t;
            default: cand_sel = cand_dc;
        endcase
    end

    // Quantised residual and reconstruction of the edges handed to later blocks
    always_comb begin
        rq_nxt[0] = quant(sext(y[0]) - cand_sel, qstep);
        for (int i = 1; i < MEA_N; i++)
            rq_nxt[i] = quant(sext(y[i]), qstep);
        rec0 = recon(rq_nxt[0], qstep, cand_sel);
`ifdef GRAD_EDGE_EN
        left_nxt = clip_edge((REC_W+1)'(rec0) - (REC_W+1)'(recon(rq_nxt[G_H_IDX], qstep, '0)));
        lb_nxt   = clip_edge((REC_W+1)'(rec0) - (REC_W+1)'(recon(rq_nxt[G_V_IDX], qstep, '0)));
`else
        left_nxt = clip_edge((REC_W+1)'(rec0));
        lb_nxt   = left_nxt;
`endif
    end

    // Output register, raster counters and left edge advance on each accepted block
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            y_resQ     <= '0;
            code       <= CODE_DC;
            blk_x      <= '0;
            blk_y      <= '0;
            frame_done <= 1'b0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            left_edge  <= '0;
        end else if (in_fire) begin
            out_valid  <= 1'b1;
            y_resQ     <= rq_nxt;
            code       <= code_nxt;
            blk_x      <= cx;
            blk_y      <= cy;
            frame_done <= last_x & last_y;
            cnt_x      <= last_x ? '0 : cx + 1'b1;
            cnt_y      <= last_x ? (last_y ? '0 : cy + 1'b1) : cy;
            left_edge  <= left_nxt;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Top-edge line buffer: read above is combinational, so this write only serves the next row
    always_ff @(posedge clk) begin
        if (!rst && in_fire)
            lb[cx] <= lb_nxt;
    end
endmodule

// File: tb/tb_meas_pred_pipe.sv
// Directed bench for meas_pred_pipe on a 2x2-block picture.
// Table-driven streaming vectors with hand-computed results, then stall and reset sequences.
// Expected values all derived by hand from the predictor rules.
module tb_meas_pred_pipe;
    localparam int MEA_N = 12;
    localparam int MW    = 13;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, sof, out_valid, out_ready, frame_done;
    logic [MEA_N-1:0][MW-1:0] y, y_resQ;
    logic [2:0] qstep;
    logic [1:0] code;
    logic [0:0] blk_x, blk_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    meas_pred_pipe #(.PIC_WID_IN_BLK(2), .PIC_HT_IN_BLK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sof(sof),
        .y(y), .qstep(qstep), .out_valid(out_valid), .out_ready(out_ready),
        .y_resQ(y_resQ), .code(code), .blk_x(blk_x), .blk_y(blk_y), .frame_done(frame_done)
    );

    typedef struct {
        logic sof; int q; int y0; int y3;
        int code; int r0; int r3; int bx; int by; int fd;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string tag, input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0d want %0d", tag, name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input int q, input int y0, input int y3);
        in_valid = 1'b1;
        sof      = s;
        qstep    = 3'(q);
        y        = '0;
        y[0]     = MW'(y0);
        y[3]     = MW'(y3);
    endtask

    task automatic chk_out(input string tag, input int c, input int r0, input int r3,
                           input int bx, input int by, input int fd);
        logic [MW-1:0] rest;
        rest = '0;
        for (int i = 0; i < MEA_N; i++)
            if (i != 0 && i != 3) rest = rest | y_resQ[i];
        chk(tag, "out_valid", 32'(out_valid), 1);
        chk(tag, "code", 32'(code), c);
        chk(tag, "res0", $signed(y_resQ[0]), r0);
        chk(tag, "res3", $signed(y_resQ[3]), r3);
        chk(tag, "res_rest", 32'(rest), 0);
        chk(tag, "blk_x", 32'(blk_x), bx);
        chk(tag, "blk_y", 32'(blk_y), by);
        chk(tag, "frame_done", 32'(frame_done), fd);
    endtask

    initial begin
        //        sof q  y0     y3   code r0     r3   bx by fd
        tv[0]  = '{1, 0, 2048,  0,   3,   0,     0,   0, 0, 0};
        tv[1]  = '{0, 0, 1600,  0,   3,   -448,  0,   1, 0, 0};
        tv[2]  = '{0, 0, 1600,  0,   3,   -448,  0,   0, 1, 0};
        tv[3]  = '{0, 0, 1600,  0,   1,   0,     0,   1, 1, 1};
        tv[4]  = '{0, 0, 1600,  0,   3,   -448,  0,   0, 0, 0};
        tv[5]  = '{0, 0, 1600,  -30, 0,   0,     -30, 1, 0, 0};
        tv[6]  = '{0, 0, 1600,  0,   1,   0,     0,   0, 1, 0};
        tv[7]  = '{0, 2, 2100,  -30, 3,   13,    -8,  1, 1, 1};
        tv[8]  = '{1, 2, 1995,  0,   3,   -14,   0,   0, 0, 0};
        tv[9]  = '{0, 0, 1984,  0,   0,   0,     0,   1, 0, 0};
        tv[10] = '{1, 0, -4096, 0,   3,   -4096, 0,   0, 0, 0};
        tv[11] = '{0, 0, 0,     0,   0,   0,     0,   1, 0, 0};
        tv[12] = '{0, 0, 5,     0,   1,   5,     0,   0, 1, 0};
        tv[13] = '{0, 0, 1000,  0,   1,   1000,  0,   1, 1, 1};

        rst = 1'b1; in_valid = 1'b0; sof = 1'b0; qstep = '0; y = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset", "out_valid", 32'(out_valid), 0);
        chk("reset", "code", 32'(code), 3);
        chk("reset", "y_resQ", 32'(|y_resQ), 0);
        chk("reset", "blk_xy", 32'({blk_x, blk_y}), 0);
        chk("reset", "frame_done", 32'(frame_done), 0);
        chk("reset", "in_ready", 32'(in_ready), 1);

        // Streaming table: one block per clock, result checked one clock later
        for (int k = 0; k < 14; k++) begin
            drive(tv[k].sof, tv[k].q, tv[k].y0, tv[k].y3);
            @(posedge clk); #1;
            chk_out($sformatf("v%0d", k), tv[k].code, tv[k].r0, tv[k].r3,
                    tv[k].bx, tv[k].by, tv[k].fd);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain", "out_valid", 32'(out_valid), 0);

        // Downstream stall with a waiting block: output held, block B not lost
        out_ready = 1'b0;
        drive(1'b1, 0, 1600, 0);
        @(posedge clk); #1;
        chk_out("stallA", 3, -448, 0, 0, 0, 0);
        drive(1'b0, 0, 1600, 7);
        for (int c = 0; c < 5; c++) begin
            chk("stall", "in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            chk_out($sformatf("stall%0d", c), 3, -448, 0, 0, 0, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall", "in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk_out("stallB", 0, 0, 7, 1, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stall_drain", "out_valid", 32'(out_valid), 0);

        // Synchronous reset mid-stream drops the presented block and restarts counters
        drive(1'b1, 0, 2048, 0);
        @(posedge clk); #1;
        drive(1'b0, 0, 2048, 0);
        @(posedge clk); #1;
        chk("pre_rst", "blk_x", 32'(blk_x), 1);
        rst = 1'b1;
        drive(1'b0, 0, 100, 0);
        @(posedge clk); #1;
        chk("rst_mid", "out_valid", 32'(out_valid), 0);
        chk("rst_mid", "code", 32'(code), 3);
        chk("rst_mid", "blk_x", 32'(blk_x), 0);
        rst = 1'b0;
        drive(1'b0, 0, 1600, 0);
        @(posedge clk); #1;
        chk_out("post_rst", 3, -448, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
